// File: rtl/exec_cc_mreg_pkg.sv
// Shared definitions for the execute-stage condition-code / E->M register slice.
// Contents:
//   - icode constants for NOP, cmovXX and jXX
//   - condition selector (ifun) constants
//   - the "no register" destination ID
//   - CC bit positions and the CC reset value
package exec_cc_mreg_pkg;

  // Instruction codes this slice cares about.
  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] ICMOV = 4'h2;
  localparam logic [3:0] IJXX  = 4'h7;

  // Condition selectors carried in ifun for cmovXX / jXX.
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  // Destination ID meaning "no register written".
  localparam logic [3:0] RNONE = 4'hF;

  // Bit positions inside the 3-bit CC word.
  localparam int unsigned CC_ZF = 2;
  localparam int unsigned CC_SF = 1;
  localparam int unsigned CC_OF = 0;

  // Flags after reset: ZF set, SF and OF clear.
  localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/exec_cc_mreg_cond_eval.sv
// cond_eval: purely combinational branch / cmov condition evaluator.
// Kept standalone so a fetch-side predictor check can reuse it.
// Ports:
//   cc   [2:0] condition codes, [2]=ZF [1]=SF [0]=OF
//   ifun [3:0] condition selector
//   cnd        1 when the selected condition holds (selectors 7..15 give 0)
module cond_eval
  import exec_cc_mreg_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd
);

  logic zf, sf, of, lt;

  assign zf = cc[CC_ZF];
  assign sf = cc[CC_SF];
  assign of = cc[CC_OF];
  // Signed "less than" after a subtract-style compare.
  assign lt = sf ^ of;

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves cnd
    // unassigned, which would otherwise infer a latch.
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = lt | zf;
      C_L:     cnd = lt;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~lt;
      C_G:     cnd = ~lt & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_cc_mreg.sv
// exec_cc_mreg: execute-stage condition-code register, Cnd evaluation,
// cmov destination cancel and the E->M pipeline register.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   e_icode, e_ifun          instruction / function code in execute
//   e_valE, e_valA           ALU result and passthrough operand (W bits)
//   e_CC, set_cc             ALU flags and their load enable
//   e_dstE, e_dstM           destination register IDs
//   m_stall, m_bubble        M register hold / NOP injection
//   e_Cnd                    combinational condition from current CC
//   cc_q                     current CC register
//   M_*                      registered execute results for the memory stage
module exec_cc_mreg
  import exec_cc_mreg_pkg::ICMOV, exec_cc_mreg_pkg::CC_RESET;
#(
  parameter int unsigned W         = 64,
  parameter logic [3:0]  NOP_ICODE = 4'h1,
  parameter logic [3:0]  RNONE     = exec_cc_mreg_pkg::RNONE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   e_icode,
  input  logic [3:0]   e_ifun,
  input  logic [W-1:0] e_valE,
  input  logic [2:0]   e_CC,
  input  logic         set_cc,
  input  logic [W-1:0] e_valA,
  input  logic [3:0]   e_dstE,
  input  logic [3:0]   e_dstM,
  input  logic         m_stall,
  input  logic         m_bubble,
  output logic         e_Cnd,
  output logic [2:0]   cc_q,
  output logic [3:0]   M_icode,
  output logic         M_Cnd,
  output logic [W-1:0] M_valE,
  output logic [W-1:0] M_valA,
  output logic [3:0]   M_dstE,
  output logic [3:0]   M_dstM
);

  logic [3:0] dst_e_eff;

  // Cnd is evaluated from the registered flags only: an instruction that
  // also sets CC this cycle still sees the previous flags.
  cond_eval u_cond_eval (
    .cc   (cc_q),
    .ifun (e_ifun),
    .cnd  (e_Cnd)
  );

  // A cmov whose condition fails must not write its destination.
  assign dst_e_eff = (e_icode == ICMOV && !e_Cnd) ? RNONE : e_dstE;

  // CC register. Pipeline hazards are handled upstream by gating set_cc,
  // so stall/bubble deliberately do not touch it.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all clocked state so every register
    // samples pre-edge values regardless of statement order.
    if (rst)         cc_q <= CC_RESET;
    else if (set_cc) cc_q <= e_CC;
  end

  // E->M register: reset and bubble both inject a NOP, bubble beats stall.
  always_ff @(posedge clk) begin
    if (rst || m_bubble) begin
      M_icode <= NOP_ICODE;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (!m_stall) begin
      M_icode <= e_icode;
      M_Cnd   <= e_Cnd;
      M_valE  <= e_valE;
      M_valA  <= e_valA;
      M_dstE  <= dst_e_eff;
      M_dstM  <= e_dstM;
    end
  end

endmodule

// File: tb/tb_exec_cc_mreg.sv
// Self-checking bench for exec_cc_mreg. Every cycle the expected M register
// contents are computed from a reference model and pushed to a scoreboard;
// after the clock edge the entry is popped and compared with the DUT.
module tb_exec_cc_mreg;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   e_icode, e_ifun, e_dstE, e_dstM;
  logic [W-1:0] e_valE, e_valA;
  logic [2:0]   e_CC;
  logic         set_cc, m_stall, m_bubble;
  logic         e_Cnd;
  logic [2:0]   cc_q;
  logic [3:0]   M_icode, M_dstE, M_dstM;
  logic         M_Cnd;
  logic [W-1:0] M_valE, M_valA;

  exec_cc_mreg #(.W(W), .NOP_ICODE(4'h1), .RNONE(4'hF)) dut (
    .clk      (clk),
    .rst      (rst),
    .e_icode  (e_icode),
    .e_ifun   (e_ifun),
    .e_valE   (e_valE),
    .e_CC     (e_CC),
    .set_cc   (set_cc),
    .e_valA   (e_valA),
    .e_dstE   (e_dstE),
    .e_dstM   (e_dstM),
    .m_stall  (m_stall),
    .m_bubble (m_bubble),
    .e_Cnd    (e_Cnd),
    .cc_q     (cc_q),
    .M_icode  (M_icode),
    .M_Cnd    (M_Cnd),
    .M_valE   (M_valE),
    .M_valA   (M_valA),
    .M_dstE   (M_dstE),
    .M_dstM   (M_dstM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   icode;
    logic         cnd;
    logic [W-1:0] val_e;
    logic [W-1:0] val_a;
    logic [3:0]   dst_e;
    logic [3:0]   dst_m;
  } mreg_t;

  mreg_t      sb_q[$];
  mreg_t      mdl_m;
  logic [2:0] mdl_cc;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference condition table written straight from the flag definitions.
  function automatic logic ref_cnd(input logic [2:0] cc, input logic [3:0] ifun);
    logic zf, sf, of;
    zf = cc[2]; sf = cc[1]; of = cc[0];
    case (ifun)
      4'd0:    return 1'b1;
      4'd1:    return (sf != of) || zf;
      4'd2:    return sf != of;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return sf == of;
      4'd6:    return (sf == of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic mreg_t nop_m();
    mreg_t m;
    m.icode = 4'h1; m.cnd = 1'b0; m.val_e = '0; m.val_a = '0;
    m.dst_e = 4'hF; m.dst_m = 4'hF;
    return m;
  endfunction

  // One clock: model the next M value from the present inputs, push it,
  // let the edge happen, then pop and compare against the DUT.
  task automatic tick();
    mreg_t nxt, got;
    logic  c;
    logic [2:0] nxt_cc;
    c = ref_cnd(mdl_cc, e_ifun);
    if (rst || m_bubble) nxt = nop_m();
    else if (m_stall)    nxt = mdl_m;
    else begin
      nxt.icode = e_icode;
      nxt.cnd   = c;
      nxt.val_e = e_valE;
      nxt.val_a = e_valA;
      nxt.dst_e = (e_icode == 4'h2 && !c) ? 4'hF : e_dstE;
      nxt.dst_m = e_dstM;
    end
    nxt_cc = rst ? 3'b100 : (set_cc ? e_CC : mdl_cc);
    sb_q.push_back(nxt);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("m_icode", {60'd0, M_icode}, {60'd0, got.icode});
    check("m_cnd",   {63'd0, M_Cnd},   {63'd0, got.cnd});
    check("m_vale",  M_valE,           got.val_e);
    check("m_vala",  M_valA,           got.val_a);
    check("m_dste",  {60'd0, M_dstE},  {60'd0, got.dst_e});
    check("m_dstm",  {60'd0, M_dstM},  {60'd0, got.dst_m});
    check("cc_q",    {61'd0, cc_q},    {61'd0, nxt_cc});
    mdl_m  = got;
    mdl_cc = nxt_cc;
  endtask

  task automatic load_cc(input logic [2:0] v);
    set_cc = 1'b1; e_CC = v;
    tick();
    set_cc = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mdl_m  = nop_m();
    mdl_cc = 3'b100;
    rst = 1'b1; set_cc = 1'b1; e_CC = 3'b011;
    e_icode = 4'h6; e_ifun = 4'h0; e_valE = 64'h1234; e_valA = 64'h5678;
    e_dstE = 4'h1; e_dstM = 4'h2; m_stall = 1'b0; m_bubble = 1'b0;

    // Reset for two cycles with a CC load requested.
    tick(); tick();
    check("rst_cc",    {61'd0, cc_q},    64'h4);
    check("rst_icode", {60'd0, M_icode}, 64'h1);
    check("rst_dste",  {60'd0, M_dstE},  64'hF);
    check("rst_dstm",  {60'd0, M_dstM},  64'hF);
    check("rst_vale",  M_valE,           64'h0);

    // CC load: the same cycle still reads the old flags.
    rst = 1'b0; set_cc = 1'b1; e_CC = 3'b010; e_ifun = 4'h2;
    #1 check("old_flags_cnd", {63'd0, e_Cnd}, 64'h0);
    tick();
    set_cc = 1'b0;
    check("new_cc", {61'd0, cc_q}, 64'h2);
    #1 check("new_l_cnd", {63'd0, e_Cnd}, 64'h1);
    e_ifun = 4'h5;
    #1 check("new_ge_cnd", {63'd0, e_Cnd}, 64'h0);

    // Full condition sweep, including the undefined selectors.
    for (int c = 0; c < 8; c++) begin
      load_cc(c[2:0]);
      for (int f = 0; f < 16; f++) begin
        e_ifun = f[3:0];
        #1 check($sformatf("sweep_cc%0d_f%0d", c, f), {63'd0, e_Cnd},
                 {63'd0, ref_cnd(c[2:0], f[3:0])});
      end
    end
    load_cc(3'b011);
    e_ifun = 4'h1; #1 check("spot_le",  {63'd0, e_Cnd}, 64'h0);
    e_ifun = 4'h6; #1 check("spot_g",   {63'd0, e_Cnd}, 64'h1);
    e_ifun = 4'h7; #1 check("spot_f7",  {63'd0, e_Cnd}, 64'h0);

    // Cmov cancel, then cmov taken.
    load_cc(3'b100);
    e_icode = 4'h2; e_ifun = 4'h4; e_dstE = 4'h3; e_valE = 64'hDEAD;
    tick();
    check("cmov_ne_dste", {60'd0, M_dstE}, 64'hF);
    check("cmov_ne_cnd",  {63'd0, M_Cnd},  64'h0);
    check("cmov_ne_vale", M_valE,          64'hDEAD);
    e_ifun = 4'h3;
    tick();
    check("cmov_e_dste", {60'd0, M_dstE}, 64'h3);
    check("cmov_e_cnd",  {63'd0, M_Cnd},  64'h1);

    // Stall holds M, then bubble wins over stall.
    e_icode = 4'h6; e_ifun = 4'h0; e_valE = 64'h1; e_dstE = 4'h2;
    tick();
    m_stall = 1'b1;
    e_valE = 64'h55; e_dstE = 4'h7;
    tick();
    e_valE = 64'h77; e_dstE = 4'h9;
    tick();
    check("stall_vale", M_valE,          64'h1);
    check("stall_dste", {60'd0, M_dstE}, 64'h2);
    m_bubble = 1'b1;
    tick();
    check("bubble_icode", {60'd0, M_icode}, 64'h1);
    check("bubble_dste",  {60'd0, M_dstE},  64'hF);
    check("bubble_vale",  M_valE,           64'h0);
    check("bubble_cc",    {61'd0, cc_q},    64'h4);
    m_stall = 1'b0; m_bubble = 1'b0;

    // Randomised traffic through the scoreboard.
    for (int i = 0; i < 40; i++) begin
      e_icode  = 4'($urandom_range(0, 15));
      e_ifun   = 4'($urandom_range(0, 7));
      e_valE   = {$urandom, $urandom};
      e_valA   = {$urandom, $urandom};
      e_dstE   = 4'($urandom_range(0, 15));
      e_dstM   = 4'($urandom_range(0, 15));
      e_CC     = 3'($urandom_range(0, 7));
      set_cc   = ($urandom_range(0, 1) == 1);
      m_stall  = ($urandom_range(0, 3) == 0);
      m_bubble = ($urandom_range(0, 5) == 0);
      tick();
    end

    // Reset mid-operation with a CC load and a valid instruction present.
    m_stall = 1'b0; m_bubble = 1'b0;
    load_cc(3'b001);
    rst = 1'b1; set_cc = 1'b1; e_CC = 3'b011;
    e_icode = 4'h2; e_ifun = 4'h0; e_valE = 64'hBEEF; e_valA = 64'hCAFE;
    e_dstE = 4'h4; e_dstM = 4'h5;
    tick();
    check("mid_rst_cc",    {61'd0, cc_q},    64'h4);
    check("mid_rst_icode", {60'd0, M_icode}, 64'h1);
    check("mid_rst_cnd",   {63'd0, M_Cnd},   64'h0);
    check("mid_rst_vale",  M_valE,           64'h0);
    check("mid_rst_vala",  M_valA,           64'h0);
    check("mid_rst_dste",  {60'd0, M_dstE},  64'hF);
    check("mid_rst_dstm",  {60'd0, M_dstM},  64'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
